// File: rtl/fnd_scan_controller_if.sv
// Display-side bundle of the FND scan controller: value/dot inputs and
// the active-low digit/segment pins.
interface fnd_scan_controller_if;
  logic [13:0] count;
  logic [3:0]  dot_en;
  logic [3:0]  fnd_digit;
  logic [7:0]  fnd_data;

  modport master (
    output count,
    output dot_en,
    input  fnd_digit,
    input  fnd_data
  );

  modport slave (
    input  count,
    input  dot_en,
    output fnd_digit,
    output fnd_data
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Four-digit time-multiplexed common-anode 7-segment driver. It captures
// the count once per frame and scans its decimal digits out at SCAN_DIV clocks per digit.
module fnd_scan_controller #(
  parameter int unsigned SCAN_DIV = 100_000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  fnd_scan_controller_if.slave bus
);

  localparam int unsigned    DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic [1:0]    r_idx;
  logic [13:0]   r_shadow;
  logic [3:0]    r_dot_sh;
  logic [3:0]    r_fnd_digit;
  logic [7:0]    r_fnd_data;

  logic          w_tick;
  logic          w_wrap;
  logic [1:0]    w_idx_nxt;
  logic [13:0]   w_shadow_nxt;
  logic [3:0]    w_dot_nxt;
  logic [13:0]   w_q10;
  logic [13:0]   w_q100;
  logic [13:0]   w_q1000;
  logic [3:0]    w_dig [4];
  logic [3:0]    w_lz;
  logic          w_oor;
  logic [7:0]    w_code;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign w_tick       = (r_div_cnt == DIV_LAST);
  assign w_wrap       = w_tick && (r_idx == 2'd3);
  assign w_idx_nxt    = w_tick ? r_idx + 2'd1 : r_idx;
  assign w_shadow_nxt = w_wrap ? bus.count  : r_shadow;
  assign w_dot_nxt    = w_wrap ? bus.dot_en : r_dot_sh;

  // Outputs are decoded from next-state idx/shadow so the pins register on
  // the same edge as the scan position and the frame capture.
  assign w_q10    = w_shadow_nxt / 14'd10;
  assign w_q100   = w_shadow_nxt / 14'd100;
  assign w_q1000  = w_shadow_nxt / 14'd1000;
  assign w_dig[0] = 4'(w_shadow_nxt % 14'd10);
  assign w_dig[1] = 4'(w_q10   % 14'd10);
  assign w_dig[2] = 4'(w_q100  % 14'd10);
  assign w_dig[3] = 4'(w_q1000 % 14'd10);

  assign w_lz  = {w_shadow_nxt < 14'd1000, w_shadow_nxt < 14'd100,
                  w_shadow_nxt < 14'd10, 1'b0};
  assign w_oor = (w_shadow_nxt > 14'd9999);

  always_comb begin
    w_code = seg7(w_dig[w_idx_nxt]);
    if (w_oor) begin
      w_code = 8'hBF;
    end else if (BLANK_LZ && w_lz[w_idx_nxt]) begin
      w_code = 8'hFF;
    end
    if (w_dot_nxt[w_idx_nxt]) begin
      w_code[7] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt   <= '0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_dot_sh    <= '0;
      r_fnd_digit <= 4'b1110;
      r_fnd_data  <= 8'hC0;
    end else begin
      r_div_cnt   <= w_tick ? '0 : r_div_cnt + DW'(1);
      r_idx       <= w_idx_nxt;
      r_shadow    <= w_shadow_nxt;
      r_dot_sh    <= w_dot_nxt;
      r_fnd_digit <= ~(4'b0001 << w_idx_nxt);
      r_fnd_data  <= w_code;
    end
  end

  assign bus.fnd_digit = r_fnd_digit;
  assign bus.fnd_data  = r_fnd_data;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: two instances (leading-zero blanking on/off)
// checked every cycle against a decimal-arithmetic display model.
module tb_fnd_scan_controller;

  localparam int S = 4;
  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] count;
  logic [3:0]  dot_en;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  fnd_scan_controller_if ifc0 ();
  fnd_scan_controller_if ifc1 ();

  assign ifc0.count  = count;
  assign ifc0.dot_en = dot_en;
  assign ifc1.count  = count;
  assign ifc1.dot_en = dot_en;

  fnd_scan_controller #(.SCAN_DIV(S), .BLANK_LZ(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(ifc0)
  );
  fnd_scan_controller #(.SCAN_DIV(S), .BLANK_LZ(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(ifc1)
  );

  always #5 clk = ~clk;

  // Model: n = clock edges since the last reset edge; the scan slot is n/S
  // mod 4, and a new frame value is latched whenever n reaches a multiple of 4*S.
  int          m_n = 0;
  int          m_shadow = 0;
  logic [3:0]  m_dot = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_n      = 0;
      m_shadow = 0;
      m_dot    = '0;
      m_valid  = 1'b1;
    end else begin
      m_n = m_n + 1;
      if (m_n % (4 * S) == 0) begin
        m_shadow = int'(count);
        m_dot    = dot_en;
      end
    end
  end

  function automatic logic [7:0] exp_code(int v, logic [3:0] dots, int slot, bit blank);
    int p;
    logic [7:0] c;
    p = 1;
    for (int k = 0; k < slot; k++) p = p * 10;
    if (v > 9999) c = 8'hBF;
    else if (blank && slot > 0 && v < p) c = 8'hFF;
    else c = SEG[(v / p) % 10];
    if (dots[slot]) c[7] = 1'b0;
    return c;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid && !done) begin
      int slot;
      logic [3:0] ed;
      slot = (m_n / S) % 4;
      ed   = 4'b0001 << slot;
      ed   = ~ed;
      chk("model_digit_lz1", {4'h0, ifc0.fnd_digit}, {4'h0, ed});
      chk("model_data_lz1",  ifc0.fnd_data, exp_code(m_shadow, m_dot, slot, 1'b1));
      chk("model_digit_lz0", {4'h0, ifc1.fnd_digit}, {4'h0, ed});
      chk("model_data_lz0",  ifc1.fnd_data, exp_code(m_shadow, m_dot, slot, 1'b0));
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [3:0] dig, input logic [7:0] d0,
                     input logic [7:0] d1);
    chk({name, "_digit"}, {4'h0, ifc0.fnd_digit}, {4'h0, dig});
    chk({name, "_lz1"},   ifc0.fnd_data, d0);
    chk({name, "_lz0"},   ifc1.fnd_data, d1);
  endtask

  initial begin
    reset  = 1'b0;
    count  = 14'd1234;
    dot_en = 4'b0000;
    step(2);
    lit("reset", 4'b1110, 8'hC0, 8'hC0);
    reset = 1'b1;
    step(3);  lit("hold_n3",   4'b1110, 8'hC0, 8'hC0);
    step(1);  lit("first_tick", 4'b1101, 8'hFF, 8'hC0);
    step(12); lit("s1234_d0",  4'b1110, 8'h99, 8'h99);
    step(4);  lit("s1234_d1",  4'b1101, 8'hB0, 8'hB0);
    step(4);  lit("s1234_d2",  4'b1011, 8'hA4, 8'hA4);
    step(4);  lit("s1234_d3",  4'b0111, 8'hF9, 8'hF9);
    step(4);  lit("s1234_rep", 4'b1110, 8'h99, 8'h99);
    step(4);  lit("coh_d1",    4'b1101, 8'hB0, 8'hB0);
    count = 14'd5678;
    step(4);  lit("coh_d2",    4'b1011, 8'hA4, 8'hA4);
    step(4);  lit("coh_d3",    4'b0111, 8'hF9, 8'hF9);
    step(4);  lit("s5678_d0",  4'b1110, 8'h80, 8'h80);
    count = 14'd7;
    step(4);  lit("s5678_d1",  4'b1101, 8'hF8, 8'hF8);
    step(4);  lit("s5678_d2",  4'b1011, 8'h82, 8'h82);
    step(4);  lit("s5678_d3",  4'b0111, 8'h92, 8'h92);
    step(4);  lit("s7_d0",     4'b1110, 8'hF8, 8'hF8);
    count = 14'd50;
    step(4);  lit("s7_d1",     4'b1101, 8'hFF, 8'hC0);
    step(8);  lit("s7_d3",     4'b0111, 8'hFF, 8'hC0);
    step(4);  lit("s50_d0",    4'b1110, 8'hC0, 8'hC0);
    count  = 14'd12000;
    dot_en = 4'b0100;
    step(4);  lit("s50_d1",    4'b1101, 8'h92, 8'h92);
    step(4);  lit("s50_d2",    4'b1011, 8'hFF, 8'hC0);
    step(8);  lit("oor_d0",    4'b1110, 8'hBF, 8'hBF);
    step(4);  lit("oor_d1",    4'b1101, 8'hBF, 8'hBF);
    step(4);  lit("oor_d2",    4'b1011, 8'h3F, 8'h3F);
    reset = 1'b0;
    step(1);  lit("mid_reset", 4'b1110, 8'hC0, 8'hC0);
    reset = 1'b1;
    step(3);  lit("mid_hold",  4'b1110, 8'hC0, 8'hC0);
    step(1);  lit("mid_tick",  4'b1101, 8'hFF, 8'hC0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 4);
      case (r)
        0: count = 14'($urandom_range(0, 9));
        1: count = 14'($urandom_range(0, 99));
        2: count = 14'($urandom_range(0, 999));
        3: count = 14'($urandom_range(0, 9999));
        default: count = 14'($urandom_range(0, 16383));
      endcase
      if ($urandom_range(0, 3) == 0) dot_en = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
    end

    @(negedge clk);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
